// File: rtl/mips_muldiv.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : mips_muldiv                                                   |
// | Purpose  : Multi-cycle MIPS multiply/divide sequencer. Owns HI/LO and    |
// |            runs MULT/MULTU (shift-add) and DIV/DIVU (restoring divide)   |
// |            as 32 iterations, plus single-cycle MTHI/MTLO.                |
// | Ports    : clk, rst_b (async active-low)                                 |
// |            md_start, md_op[2:0], md_in1[31:0], md_in2[31:0], md_flush    |
// |            md_busy, md_done, md_hi[31:0], md_lo[31:0]                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module mips_muldiv (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        md_start,
   input  logic [2:0]  md_op,
   input  logic [31:0] md_in1,
   input  logic [31:0] md_in2,
   input  logic        md_flush,
   output logic        md_busy,
   output logic        md_done,
   output logic [31:0] md_hi,
   output logic [31:0] md_lo
);

   localparam logic [2:0] MD_MTHI = 3'd4;
   localparam logic [2:0] MD_MTLO = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [31:0] opnd_q;      // multiplicand (mult) or divisor (div) magnitude
   logic [31:0] orig1_q;     // raw rs operand, returned in HI on divide by zero
   logic [63:0] acc_q;       // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
   logic [4:0]  cnt_q;
   logic        is_div_q;
   logic        neg_res_q;   // product / quotient must be negated
   logic        neg_rem_q;   // remainder must be negated
   logic        dbz_q;
   logic        done_q;

   //---------------------------------------------------------------------------
   // Issue decode
   //---------------------------------------------------------------------------
   logic        op_arith;
   logic        op_div;
   logic        op_signed;
   logic [31:0] mag1;
   logic [31:0] mag2;

   always_comb begin
      op_arith  = ~md_op[2];
      op_div    = md_op[1];
      op_signed = ~md_op[0];
      mag1      = (op_signed && md_in1[31]) ? (~md_in1 + 32'd1) : md_in1;
      mag2      = (op_signed && md_in2[31]) ? (~md_in2 + 32'd1) : md_in2;
   end

   //---------------------------------------------------------------------------
   // One iteration of the datapath
   //---------------------------------------------------------------------------
   logic [32:0] mul_sum;
   logic [32:0] div_rem_sh;
   logic [32:0] div_diff;
   logic [63:0] acc_d;

   always_comb begin
      // Multiply: add multiplicand into the upper half when the current
      // multiplier LSB is set, then shift the whole accumulator right.
      mul_sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
      // Divide: remainder shifted left with the next dividend bit (MSB of low half).
      div_rem_sh = acc_q[63:31];
      div_diff   = div_rem_sh - {1'b0, opnd_q};
      if (is_div_q) begin
         if (!div_diff[32]) begin
            acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
         end else begin
            acc_d = {div_rem_sh[31:0], acc_q[30:0], 1'b0};
         end
      end else begin
         acc_d = {mul_sum, acc_q[31:1]};
      end
   end

   //---------------------------------------------------------------------------
   // Sign correction and result selection for the commit edge
   //---------------------------------------------------------------------------
   logic [63:0] prod_fix;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;
   logic [31:0] hi_d;
   logic [31:0] lo_d;

   always_comb begin
      prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
      quo_fix  = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
      rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
      if (!is_div_q) begin
         hi_d = prod_fix[63:32];
         lo_d = prod_fix[31:0];
      end else if (dbz_q) begin
         hi_d = orig1_q;
         lo_d = 32'hFFFF_FFFF;
      end else begin
         hi_d = rem_fix;
         lo_d = quo_fix;
      end
   end

   //---------------------------------------------------------------------------
   // Sequencer
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q   <= ST_IDLE;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         opnd_q    <= 32'd0;
         orig1_q   <= 32'd0;
         acc_q     <= 64'd0;
         cnt_q     <= 5'd0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (md_start && !md_flush) begin
                  if (op_arith) begin
                     opnd_q    <= op_div ? mag2 : mag1;
                     acc_q     <= {32'd0, (op_div ? mag1 : mag2)};
                     neg_res_q <= op_signed & (md_in1[31] ^ md_in2[31]);
                     neg_rem_q <= op_signed & md_in1[31];
                     orig1_q   <= md_in1;
                     dbz_q     <= (md_in2 == 32'd0);
                     is_div_q  <= op_div;
                     cnt_q     <= 5'd0;
                     state_q   <= ST_RUN;
                  end else if (md_op == MD_MTHI) begin
                     hi_q <= md_in1;
                  end else if (md_op == MD_MTLO) begin
                     lo_q <= md_in1;
                  end
               end
            end
            ST_RUN: begin
               if (md_flush) begin
                  state_q <= ST_IDLE;
               end else begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q + 5'd1;
                  if (cnt_q == 5'd31) begin
                     state_q <= ST_FIX;
                  end
               end
            end
            ST_FIX: begin
               if (!md_flush) begin
                  hi_q   <= hi_d;
                  lo_q   <= lo_d;
                  done_q <= 1'b1;
               end
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign md_busy = (state_q != ST_IDLE);
   assign md_done = done_q;
   assign md_hi   = hi_q;
   assign md_lo   = lo_q;

endmodule

`default_nettype wire

// File: doc/mips_muldiv.md
# mips_muldiv

Multi-cycle multiply/divide sequencer that sits beside `mips_alu` in the execute stage. It owns the architectural HI/LO registers and runs MULT, MULTU, DIV and DIVU as a 32-iteration shift-add or restoring-divide loop over private working registers. It also executes MTHI/MTLO. It exposes a busy flag so the pipeline stalls MFHI/MFLO and further mult/div issue until the result is committed.

## Interface
- No parameters; datapath width is fixed at 32.
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst_b`  in  1  asynchronous, active-low reset.
- `md_start`  in  1  issue request. Sampled only when `md_busy`=0.
- `md_op`  in  3  operation. Encodings in `jpu_defines.vh`:
  - `MD_MULT`=0, `MD_MULTU`=1, `MD_DIV`=2, `MD_DIVU`=3, `MD_MTHI`=4, `MD_MTLO`=5.
  - Codes 6–7 are no-ops.
- `md_in1`  in  32  rs operand: multiplicand/dividend, or MTHI/MTLO source.
- `md_in2`  in  32  rt operand: multiplier/divisor.
- `md_flush`  in  1  abort any in-flight operation; HI/LO are left untouched.
- `md_busy`  out  1  high whenever FSM ≠ IDLE (decoded from the state register).
- `md_done`  out  1  registered, one-cycle pulse in the cycle after HI/LO commit.
- `md_hi`  out  32  architectural HI. Changes only on commit, MTHI, or reset.
- `md_lo`  out  32  architectural LO. Changes only on commit, MTLO, or reset.

## Operation
- FSM states: IDLE, RUN, FIX.
- **IDLE**, edge with `md_start`=1 and `md_flush`=0:
  - Ops 0–3:
    - Latch `|md_in1|` and `|md_in2|`. Magnitudes apply for MULT/DIV; raw values for MULTU/DIVU.
    - Latch the result-sign flags: product/quotient sign = sign1^sign2; remainder sign = sign1.
    - Latch the original `md_in1`, a divide-by-zero flag (`md_in2`==0), and the op class.
    - Clear the 5-bit iteration counter; go to RUN.
  - MTHI/MTLO: write `md_in1` to HI or LO on that edge. State stays IDLE; no busy, no done.
  - Codes 6–7: no effect.
- **RUN**, one iteration per edge; after counter reaches 31, go to FIX.
  - Multiply: unsigned shift-add into a 64-bit accumulator, one multiplier bit per edge, LSB first.
  - Divide: restoring division, one quotient bit per edge, MSB first. The 33-bit trial subtract uses the remainder register shifted left with the next dividend bit.
- **FIX**, one edge, then go to IDLE with `md_done` set for the next cycle:
  - Multiply: {HI,LO} = product, two's-complement negated (64-bit) if the product-sign flag is set.
  - Divide: LO = quotient, negated if the quotient-sign flag is set; HI = remainder, negated if the remainder-sign flag is set.
  - Divide by zero (signed or unsigned): LO=32'hFFFF_FFFF, HI=original `md_in1`, with no sign correction.
  - Signed overflow 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0. The magnitude path yields this naturally.
- `md_start` while busy is ignored. The pipeline must hold the instruction.
- `md_flush`:
  - In RUN or FIX: go to IDLE on the next edge. HI/LO are not written and `md_done` is not pulsed.
  - In IDLE: blocks acceptance of a simultaneous `md_start`, including MTHI/MTLO.
- Reset (async, `rst_b`=0):
  - State IDLE, HI=LO=0, `md_done`=0, `md_busy`=0.
  - Working registers and counter cleared.
  - Takes effect immediately, including mid-operation.

## Timing
- Accept edge E0 → RUN on E1..E32 → FIX commits HI/LO on E33.
- `md_busy` is high for 33 cycles (after E0 through before E33).
- `md_done` is high for exactly the one cycle after E33; new HI/LO are visible in that same cycle.
- A new op may be accepted on E34 (the edge ending the `md_done` cycle). Back-to-back issue gives 34 edges per op.
- MTHI/MTLO: single-cycle; the written value is visible on the outputs in the cycle after the edge.
- `md_hi`/`md_lo` never show intermediate values.

## Test plan
- MULT 0xFFFF_FFFD × 0x0000_0007 → `md_busy` high for 33 cycles, a single `md_done` pulse, HI=0xFFFF_FFFF, LO=0xFFFF_FFEB.
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → HI=0xFFFF_FFFE, LO=0x0000_0001. Then MULT on the same operands → HI=0, LO=1.
- DIV 0xFFFF_FFF9 / 0x0000_0002 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU 7/2 → LO=3, HI=1. DIV 0x8000_0000 / 0xFFFF_FFFF → LO=0x8000_0000, HI=0.
- DIVU 0x0000_1234 / 0 → after 33 cycles LO=0xFFFF_FFFF, HI=0x0000_1234. DIV 0xFFFF_FFF0 / 0 → LO=0xFFFF_FFFF, HI=0xFFFF_FFF0.
- Flush and busy-start handling:
  - MTHI 0xAAAA_0000 then MTLO 0x5555 → HI/LO updated with no busy or done.
  - Then MULT 3×4 with `md_flush` on the 10th RUN cycle → busy drops the next cycle, HI/LO remain 0xAAAA_0000/0x5555, no `md_done`.
  - A `md_start` (MTLO 0x1) asserted while busy → LO still 0x5555.
- Assert `rst_b`=0 asynchronously mid-DIVU → outputs go to 0 with no clock edge. After release, DIVU 100/7 → LO=14, HI=2 with full 33-cycle latency.
